iic_slave: RTL and testbench

I2C target (slave) byte engine that answers the `iic_rt` master on the same two-wire bus. It oversamples SCL/SDA on the system clock and detects START/STOP. It matches a 7-bit address, receives write bytes onto a parallel port, and serves read bytes from a parallel port with an open-drain SDA driver. It sits beside the master in the same design, or on a bench across the bus from it, with its own register or user logic behind it.

---
 rtl/iic_slave.sv | 224 ++++++++++++++++++++++
 tb/tb_iic_slave.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/iic_slave.sv
// I2C target byte engine: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// parallel write-byte output and read-byte input with an open-drain SDA driver.
module iic_slave #(
  parameter logic [6:0] ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       rw,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WDATA, S_WACK, S_RDATA, S_RACK, S_WAIT
  } state_t;

  logic       scl_s1_q, scl_s2_q, scl_p_q;
  logic       sda_s1_q, sda_s2_q, sda_p_q;
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       phase_q, phase_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;

  logic       scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [7:0] shift_in_s;

  assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign rw       = rw_q;
  assign busy     = busy_q;

  // Synchronizers reset to the idle-bus level so release of reset never fakes a START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; scl_p_q <= 1'b1;
      sda_s1_q <= 1'b1; sda_s2_q <= 1'b1; sda_p_q <= 1'b1;
    end else begin
      scl_s1_q <= SCL;  scl_s2_q <= scl_s1_q; scl_p_q <= scl_s2_q;
      sda_s1_q <= SDA;  sda_s2_q <= sda_s1_q; sda_p_q <= sda_s2_q;
    end
  end

  assign scl_rise_s = scl_s2_q & ~scl_p_q;
  assign scl_fall_s = ~scl_s2_q & scl_p_q;
  assign start_s    = scl_s2_q & scl_p_q & sda_p_q & ~sda_s2_q;
  assign stop_s     = scl_s2_q & scl_p_q & ~sda_p_q & sda_s2_q;
  assign shift_in_s = {shift_q[6:0], sda_s2_q};

  // Protocol state register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= 8'd0;
      phase_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      phase_q    <= phase_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic; START/STOP take priority over any bit in progress.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    phase_d    = phase_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    rw_d       = rw_q;
    busy_d     = busy_q;

    if (start_s) begin
      state_d  = S_ADDR;
      cnt_d    = 3'd0;
      phase_d  = 1'b0;
      sda_oe_d = 1'b0;
    end else if (stop_s) begin
      state_d  = S_IDLE;
      cnt_d    = 3'd0;
      phase_d  = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_ADDR: begin
          if (scl_rise_s) begin
            shift_d = shift_in_s;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (shift_in_s[7:1] == ADDR) begin
                rw_d    = shift_in_s[0];
                busy_d  = 1'b1;
                phase_d = 1'b0;
                state_d = S_ADDR_ACK;
              end else begin
                busy_d  = 1'b0;
                state_d = S_WAIT;
              end
            end else begin
              state_d = S_ADDR;
            end
          end else begin
            state_d = S_ADDR;
          end
        end
        S_ADDR_ACK, S_WACK: begin
          if (scl_fall_s) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else if ((state_q == S_ADDR_ACK) && rw_q) begin
              phase_d  = 1'b0;
              shift_d  = tx_data;
              tx_req_d = 1'b1;
              sda_oe_d = ~tx_data[7];
              cnt_d    = 3'd0;
              state_d  = S_RDATA;
            end else begin
              phase_d  = 1'b0;
              sda_oe_d = 1'b0;
              cnt_d    = 3'd0;
              state_d  = S_WDATA;
            end
          end else begin
            state_d = state_q;
          end
        end
        S_WDATA: begin
          if (scl_rise_s) begin
            shift_d = shift_in_s;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_data_d  = shift_in_s;
              rx_valid_d = 1'b1;
              phase_d    = 1'b0;
              state_d    = S_WACK;
            end else begin
              state_d = S_WDATA;
            end
          end else begin
            state_d = S_WDATA;
          end
        end
        S_RDATA: begin
          // The bit on the wire is always shift_q[7]; rotate to bring up the next one.
          if (scl_fall_s) begin
            if (cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              cnt_d    = 3'd0;
              phase_d  = 1'b0;
              state_d  = S_RACK;
            end else begin
              shift_d  = {shift_q[6:0], shift_q[7]};
              sda_oe_d = ~shift_q[6];
              cnt_d    = cnt_q + 3'd1;
            end
          end else begin
            state_d = S_RDATA;
          end
        end
        S_RACK: begin
          if (!phase_q) begin
            if (scl_rise_s) begin
              if (sda_s2_q) begin
                busy_d  = 1'b0;
                state_d = S_WAIT;
              end else begin
                phase_d = 1'b1;
              end
            end else begin
              state_d = S_RACK;
            end
          end else if (scl_fall_s) begin
            phase_d  = 1'b0;
            shift_d  = tx_data;
            tx_req_d = 1'b1;
            sda_oe_d = ~tx_data[7];
            cnt_d    = 3'd0;
            state_d  = S_RDATA;
          end else begin
            state_d = S_RACK;
          end
        end
        S_WAIT: state_d = S_WAIT;
        default: begin
          state_d  = S_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iic_slave.sv
// Bench for iic_slave: bit-banged I2C master with a scoreboard of expected write/read bytes.
module tb_iic_slave;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m_scl;
  logic       m_sda_low;
  logic [7:0] tx_data;
  wire        sda_bus;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, rw, busy;

  int n_chk  = 0;
  int n_pass = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  int rx_extra = 0;
  logic rxv_prev = 1'b0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_rd[$];

  always #5 clk = ~clk;

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  iic_slave #(.ADDR(7'h50)) dut (
    .clk(clk), .rst_n(rst_n), .SCL(m_scl), .SDA(sda_bus),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_req(tx_req), .rw(rw), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Write-byte scoreboard and handshake pulse counters.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      chk("rxv_len", {31'd0, rxv_prev}, 32'd0);
      if (exp_rx.size() > 0) chk("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
      else rx_extra++;
    end
    if (tx_req) tx_cnt++;
    rxv_prev = rx_valid;
  end

  task automatic q();
    repeat (5) @(negedge clk);
  endtask

  task automatic bit_x(input logic b, output logic r);
    m_sda_low = ~b; q();
    m_scl = 1'b1;   q();
    r = sda_bus;    q();
    m_scl = 1'b0;   q();
  endtask

  task automatic start_c();
    m_sda_low = 1'b0; q();
    m_scl = 1'b1;     q();
    m_sda_low = 1'b1; q();
    m_scl = 1'b0;     q();
  endtask

  task automatic stop_c();
    m_sda_low = 1'b1; q();
    m_scl = 1'b1;     q();
    m_sda_low = 1'b0; q(); q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(d[i], r);
    bit_x(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, input logic [7:0] nxt, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, r);
      d[i] = r;
    end
    tx_data = nxt;
    bit_x(nack, r);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    logic       r;
    int         rx0, tx0;
    rst_n = 1'b0; m_scl = 1'b1; m_sda_low = 1'b0; tx_data = 8'h5A;
    repeat (4) @(negedge clk);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_tx_req", {31'd0, tx_req}, 32'd0);
    chk("rst_rw", {31'd0, rw}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sda", {31'd0, sda_bus}, 32'd1);
    rst_n = 1'b1;
    q();

    // Write 0xA0, 0x3C, 0xF1, STOP
    rx0 = rx_cnt;
    start_c();
    write_byte(8'hA0, ack); chk("w_addr_ack", {31'd0, ack}, 32'd0);
    chk("w_busy", {31'd0, busy}, 32'd1);
    chk("w_rw", {31'd0, rw}, 32'd0);
    exp_rx.push_back(8'h3C);
    write_byte(8'h3C, ack); chk("w_b1_ack", {31'd0, ack}, 32'd0);
    exp_rx.push_back(8'hF1);
    write_byte(8'hF1, ack); chk("w_b2_ack", {31'd0, ack}, 32'd0);
    stop_c();
    chk("w_busy_stop", {31'd0, busy}, 32'd0);
    chk("w_rx_count", rx_cnt - rx0, 32'd2);

    // Wrong address: no ACK, bytes ignored
    rx0 = rx_cnt;
    start_c();
    write_byte(8'hA2, ack); chk("mis_addr_nack", {31'd0, ack}, 32'd1);
    chk("mis_busy", {31'd0, busy}, 32'd0);
    write_byte(8'h3C, ack); chk("mis_b1_nack", {31'd0, ack}, 32'd1);
    stop_c();
    chk("mis_rx_count", rx_cnt - rx0, 32'd0);

    // Read 0x5A (ACK) then 0xC3 (NACK)
    tx0 = tx_cnt;
    tx_data = 8'h5A;
    start_c();
    write_byte(8'hA1, ack); chk("r_addr_ack", {31'd0, ack}, 32'd0);
    chk("r_rw", {31'd0, rw}, 32'd1);
    exp_rd.push_back(8'h5A);
    read_byte(1'b0, 8'hC3, d); chk("r_b1", {24'd0, d}, {24'd0, exp_rd.pop_front()});
    exp_rd.push_back(8'hC3);
    read_byte(1'b1, 8'h77, d); chk("r_b2", {24'd0, d}, {24'd0, exp_rd.pop_front()});
    chk("r_sda_rel", {31'd0, sda_bus}, 32'd1);
    chk("r_busy_nack", {31'd0, busy}, 32'd0);
    chk("r_tx_count", tx_cnt - tx0, 32'd2);
    stop_c();

    // Write 0x10, repeated START, read one byte
    tx0 = tx_cnt;
    start_c();
    write_byte(8'hA0, ack); chk("rs_w_ack", {31'd0, ack}, 32'd0);
    chk("rs_rw0", {31'd0, rw}, 32'd0);
    exp_rx.push_back(8'h10);
    write_byte(8'h10, ack); chk("rs_b_ack", {31'd0, ack}, 32'd0);
    start_c();
    write_byte(8'hA1, ack); chk("rs_r_ack", {31'd0, ack}, 32'd0);
    chk("rs_rw1", {31'd0, rw}, 32'd1);
    exp_rd.push_back(8'h77);
    read_byte(1'b1, 8'h00, d); chk("rs_rd", {24'd0, d}, {24'd0, exp_rd.pop_front()});
    stop_c();
    chk("rs_rx_data", {24'd0, rx_data}, 32'h10);
    chk("rs_tx_count", tx_cnt - tx0, 32'd1);

    // Asynchronous reset while the target holds the address ACK low
    start_c();
    for (int i = 7; i >= 0; i--) bit_x(((8'hA0 >> i) & 8'h01) != 8'h00, r);
    m_sda_low = 1'b0; q();
    chk("ack_driven", {31'd0, sda_bus}, 32'd0);
    m_scl = 1'b1; q();
    rst_n = 1'b0;
    #1;
    chk("rst_ack_rel", {31'd0, sda_bus}, 32'd1);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_mid_rw", {31'd0, rw}, 32'd0);
    q(); m_scl = 1'b0; q();
    rst_n = 1'b1; q();
    stop_c();
    start_c();
    write_byte(8'hA0, ack); chk("post_rst_ack", {31'd0, ack}, 32'd0);
    exp_rx.push_back(8'h55);
    write_byte(8'h55, ack); chk("post_rst_b_ack", {31'd0, ack}, 32'd0);
    stop_c();

    // STOP after four bits of a write byte
    rx0 = rx_cnt;
    start_c();
    write_byte(8'hA0, ack); chk("ms_addr_ack", {31'd0, ack}, 32'd0);
    bit_x(1'b1, r); bit_x(1'b0, r); bit_x(1'b1, r); bit_x(1'b1, r);
    stop_c();
    chk("ms_busy", {31'd0, busy}, 32'd0);
    chk("ms_rx_count", rx_cnt - rx0, 32'd0);
    start_c();
    write_byte(8'hA0, ack); chk("ms_again_ack", {31'd0, ack}, 32'd0);
    exp_rx.push_back(8'h66);
    write_byte(8'h66, ack); chk("ms_again_b_ack", {31'd0, ack}, 32'd0);
    stop_c();
    chk("ms_rx_data", {24'd0, rx_data}, 32'h66);

    q();
    chk("sb_left", exp_rx.size(), 32'd0);
    chk("rx_extra", rx_extra, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
